// File: rtl/matarb_pkg.sv
// Shared widths, state encoding and helpers for the matrix-memory read arbiter.
package matarb_pkg;

    localparam int SLOT_W   = 2;
    localparam int ROW_W    = 3;
    localparam int COL_W    = 3;
    localparam int DATA_W   = 16;
    localparam int STAT_W   = 16;
    localparam int NREQ_DEF = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARB    = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mat_rd_arbiter_rr_picker.sv
// Round-robin picker: first set bit of req_vec at or after start, wrapping modulo N.
module rr_picker
    import matarb_pkg::*;
#(
    parameter int N  = NREQ_DEF,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_vec,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          found
);

    always_comb begin
        logic [IW:0] pos;
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, start} + (IW+1)'(k);
            if (pos >= (IW+1)'(N))
                pos = pos - (IW+1)'(N);
            if (!found && req_vec[pos[IW-1:0]]) begin
                found                 = 1'b1;
                onehot[pos[IW-1:0]]   = 1'b1;
                idx                   = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/mat_rd_arbiter.sv
// Round-robin read arbiter with burst locking in front of the matrix memory.
// Optional per-requester grant statistics are enabled with MATARB_STATS_EN.
module mat_rd_arbiter
    import matarb_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int MEM_LAT  = 1,
    parameter int LOCK_MAX = 64
) (
`ifdef MATARB_STATS_EN
    input  logic                     stat_clr,
    output logic [NREQ*STAT_W-1:0]   stat_gnt_cnt,
`endif
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ*SLOT_W-1:0]   req_slot,
    input  logic [NREQ*ROW_W-1:0]    req_row,
    input  logic [NREQ*COL_W-1:0]    req_col,
    output logic [NREQ-1:0]          gnt,
    output logic [SLOT_W-1:0]        mem_rd_slot,
    output logic [ROW_W-1:0]         mem_rd_row,
    output logic [COL_W-1:0]         mem_rd_col,
    input  logic [DATA_W-1:0]        mem_rd_data,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     busy
);

    localparam int IW = idx_w(NREQ);
    localparam int CW = $clog2(LOCK_MAX + 1);

    state_t                    state, state_nxt;
    logic [IW-1:0]             last_gnt, owner, owner_nxt;
    logic [IW-1:0]             start_idx, pick_idx, gnt_idx;
    logic [CW-1:0]             lock_cnt, lock_cnt_nxt;
    logic [NREQ-1:0]           cand, pick, gnt_int;
    logic                      pick_found, force_rel, holding, in_flight;
    logic [NREQ-1:0][SLOT_W-1:0] slot_arr;
    logic [NREQ-1:0][ROW_W-1:0]  row_arr;
    logic [NREQ-1:0][COL_W-1:0]  col_arr;
    logic [NREQ-1:0]           rsp_pipe [MEM_LAT+1];

    assign slot_arr = req_slot;
    assign row_arr  = req_row;
    assign col_arr  = req_col;

    // A forced release turns the locked cycle into an arbitration that skips the owner.
    always_comb begin
        force_rel = (state == S_LOCKED) && (lock_cnt == CW'(LOCK_MAX));
        holding   = (state == S_LOCKED) && lock[owner] && !force_rel;
        start_idx = (last_gnt == IW'(NREQ - 1)) ? '0 : last_gnt + 1'b1;
        cand      = req;
        if (force_rel)
            cand[owner] = 1'b0;
    end

    rr_picker #(.N(NREQ), .IW(IW)) u_picker (
        .req_vec (cand),
        .start   (start_idx),
        .onehot  (pick),
        .idx     (pick_idx),
        .found   (pick_found)
    );

    always_comb begin
        gnt_int      = '0;
        gnt_idx      = pick_idx;
        state_nxt    = state;
        owner_nxt    = owner;
        lock_cnt_nxt = lock_cnt;
        if (holding) begin
            gnt_int[owner] = req[owner];
            gnt_idx        = owner;
            lock_cnt_nxt   = lock_cnt + 1'b1;
        end else if (pick_found) begin
            gnt_int = pick;
            if (lock[pick_idx]) begin
                state_nxt    = S_LOCKED;
                owner_nxt    = pick_idx;
                lock_cnt_nxt = CW'(1);
            end else begin
                state_nxt    = S_ARB;
                lock_cnt_nxt = '0;
            end
        end else begin
            state_nxt    = S_IDLE;
            lock_cnt_nxt = '0;
        end
    end

    assign gnt = rst_n ? gnt_int : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            owner       <= '0;
            lock_cnt    <= '0;
            last_gnt    <= IW'(NREQ - 1);
            mem_rd_slot <= '0;
            mem_rd_row  <= '0;
            mem_rd_col  <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            lock_cnt <= lock_cnt_nxt;
            if (|gnt_int) begin
                last_gnt    <= gnt_idx;
                mem_rd_slot <= slot_arr[gnt_idx];
                mem_rd_row  <= row_arr[gnt_idx];
                mem_rd_col  <= col_arr[gnt_idx];
            end
        end
    end

    // Stage 0 covers the address cycle; the last stage lines up with valid memory data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= MEM_LAT; k++)
                rsp_pipe[k] <= '0;
        end else begin
            rsp_pipe[0] <= gnt_int;
            for (int k = 1; k <= MEM_LAT; k++)
                rsp_pipe[k] <= rsp_pipe[k-1];
        end
    end

    always_comb begin
        in_flight = 1'b0;
        for (int k = 0; k <= MEM_LAT; k++)
            in_flight = in_flight | (|rsp_pipe[k]);
    end

    assign rsp_valid = rsp_pipe[MEM_LAT];
    assign rsp_data  = mem_rd_data;
    assign busy      = (state != S_IDLE) || in_flight;

`ifdef MATARB_STATS_EN
    logic [NREQ-1:0][STAT_W-1:0] stat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt <= '0;
        end else if (stat_clr) begin
            stat_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (gnt_int[i] && (stat_cnt[i] != '1))
                    stat_cnt[i] <= stat_cnt[i] + 1'b1;
        end
    end

    assign stat_gnt_cnt = stat_cnt;
`endif

endmodule

// File: tb/tb_mat_rd_arbiter.sv
// Bench for mat_rd_arbiter: two instances (LOCK_MAX 64 and 4) share stimulus and are
// checked every cycle against a queue-based reference model; set MATARB_STATS_EN for stats.
module tb_mat_rd_arbiter;
    import matarb_pkg::*;

    localparam int N   = 3;
    localparam int LAT = 1;

    typedef struct {
        int          due;
        int          idx;
        logic [15:0] data;
    } rsp_t;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [2:0]  req      = '0;
    logic [2:0]  lock     = '0;
    logic [5:0]  req_slot = '0;
    logic [8:0]  req_row  = '0;
    logic [8:0]  req_col  = '0;

    logic [2:0]  gnt       [2];
    logic [2:0]  rsp_valid [2];
    logic [1:0]  mem_slot  [2];
    logic [2:0]  mem_row   [2];
    logic [2:0]  mem_col   [2];
    logic [15:0] mem_data  [2];
    logic [15:0] rsp_data  [2];
    logic        busy      [2];
`ifdef MATARB_STATS_EN
    logic        stat_clr = 1'b0;
    logic [47:0] stat_cnt [2];
`endif

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   m_last [2];
    int   m_own  [2];
    int   m_cnt  [2];
    bit   m_prev [2];
    logic [7:0] m_addr [2];
    rsp_t q0[$];
    rsp_t q1[$];

    always #5 clk = ~clk;

    mat_rd_arbiter #(.NREQ(N), .MEM_LAT(LAT), .LOCK_MAX(64)) dut0 (
`ifdef MATARB_STATS_EN
        .stat_clr(stat_clr), .stat_gnt_cnt(stat_cnt[0]),
`endif
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
        .req_slot(req_slot), .req_row(req_row), .req_col(req_col),
        .gnt(gnt[0]), .mem_rd_slot(mem_slot[0]), .mem_rd_row(mem_row[0]),
        .mem_rd_col(mem_col[0]), .mem_rd_data(mem_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .busy(busy[0])
    );

    mat_rd_arbiter #(.NREQ(N), .MEM_LAT(LAT), .LOCK_MAX(4)) dut1 (
`ifdef MATARB_STATS_EN
        .stat_clr(stat_clr), .stat_gnt_cnt(stat_cnt[1]),
`endif
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
        .req_slot(req_slot), .req_row(req_row), .req_col(req_col),
        .gnt(gnt[1]), .mem_rd_slot(mem_slot[1]), .mem_rd_row(mem_row[1]),
        .mem_rd_col(mem_col[1]), .mem_rd_data(mem_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .busy(busy[1])
    );

    function automatic logic [15:0] memf(input logic [7:0] a);
        return {a ^ 8'h5A, ~a};
    endfunction

    // One-cycle memory: data follows the registered address by one edge.
    always @(posedge clk) begin
        mem_data[0] <= memf({mem_slot[0], mem_row[0], mem_col[0]});
        mem_data[1] <= memf({mem_slot[1], mem_row[1], mem_col[1]});
    end

    task automatic compareValue(input string tag, input int m, input logic [15:0] obs,
                                input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s dut%0d: observed %h expected %h", tag, m, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            m_last[m] = N - 1;
            m_own[m]  = -1;
            m_cnt[m]  = 0;
            m_prev[m] = 1'b0;
            m_addr[m] = '0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic checkOutput();
        for (int m = 0; m < 2; m++) begin
            int         lm, w, excl, j, qn;
            bit         hold, has;
            rsp_t       f;
            logic [2:0] eg, ev;
            logic [7:0] a;
            lm = (m == 0) ? 64 : 4;
            if (!rst_n) begin
                compareValue("rst_gnt", m, 16'(gnt[m]), 16'h0);
                compareValue("rst_rsp_valid", m, 16'(rsp_valid[m]), 16'h0);
                compareValue("rst_mem_addr", m, 16'({mem_slot[m], mem_row[m], mem_col[m]}), 16'h0);
                compareValue("rst_busy", m, 16'(busy[m]), 16'h0);
                continue;
            end
            has = 1'b0;
            f   = '{0, 0, 16'h0};
            if (m == 0) begin
                qn = q0.size();
                if (qn > 0 && q0[0].due == cyc) begin has = 1'b1; f = q0[0]; end
            end else begin
                qn = q1.size();
                if (qn > 0 && q1[0].due == cyc) begin has = 1'b1; f = q1[0]; end
            end
            excl = (m_own[m] >= 0 && m_cnt[m] == lm) ? m_own[m] : -1;
            hold = (m_own[m] >= 0) && lock[m_own[m]] && (excl < 0);
            w = -1;
            if (hold) begin
                if (req[m_own[m]]) w = m_own[m];
            end else begin
                for (int i = 1; i <= N; i++) begin
                    j = (m_last[m] + i) % N;
                    if (w < 0 && req[j] && j != excl) w = j;
                end
            end
            eg = (w >= 0) ? 3'(1 << w) : 3'b000;
            ev = has ? 3'(1 << f.idx) : 3'b000;
            compareValue("gnt", m, 16'(gnt[m]), 16'(eg));
            compareValue("rsp_valid", m, 16'(rsp_valid[m]), 16'(ev));
            if (has)
                compareValue("rsp_data", m, rsp_data[m], f.data);
            compareValue("mem_addr", m, 16'({mem_slot[m], mem_row[m], mem_col[m]}), 16'(m_addr[m]));
            compareValue("busy", m, 16'(busy[m]), 16'((m_own[m] >= 0) || m_prev[m] || (qn > 0)));
            if (has) begin
                if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
            if (w >= 0) begin
                a = {req_slot[2*w +: 2], req_row[3*w +: 3], req_col[3*w +: 3]};
                if (m == 0) q0.push_back('{cyc + 1 + LAT, w, memf(a)});
                else        q1.push_back('{cyc + 1 + LAT, w, memf(a)});
                m_addr[m] = a;
                m_last[m] = w;
            end
            if (hold) begin
                m_cnt[m]++;
            end else if (w >= 0 && lock[w]) begin
                m_own[m] = w;
                m_cnt[m] = 1;
            end else begin
                m_own[m] = -1;
                m_cnt[m] = 0;
            end
            m_prev[m] = (w >= 0);
        end
        if (!rst_n) modelReset();
        cyc++;
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic [2:0] l, input logic [5:0] s,
                                 input logic [8:0] rw, input logic [8:0] cl);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        req      = r;
        lock     = l;
        req_slot = s;
        req_row  = rw;
        req_col  = cl;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic resetPulse();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [2:0] exp32 [6];
        logic [2:0] lr;
        exp32 = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b001};
        modelReset();
        $display("[TB] start");
        @(negedge clk);
        checkOutput();

        // Single read: requester 1 at slot 2, row 5, col 7.
        applyStimulus(3'b010, 3'b000, {2'd0, 2'd2, 2'd0}, {3'd0, 3'd5, 3'd0}, {3'd0, 3'd7, 3'd0});
        compareValue("single_gnt", 0, 16'(gnt[0]), 16'h0002);
        applyStimulus(3'b000, 3'b000, '0, '0, '0);
        compareValue("single_addr", 0, 16'({mem_slot[0], mem_row[0], mem_col[0]}),
                     16'({2'd2, 3'd5, 3'd7}));
        applyStimulus(3'b000, 3'b000, '0, '0, '0);
        compareValue("single_rsp", 0, 16'(rsp_valid[0]), 16'h0002);
        compareValue("single_data", 0, rsp_data[0], memf({2'd2, 3'd5, 3'd7}));

        // All three requesting without lock: rotating grants, responses two cycles later.
        resetPulse();
        for (int k = 0; k < 8; k++) begin
            applyStimulus((k < 6) ? 3'b111 : 3'b000, 3'b000, 6'($urandom), 9'($urandom), 9'($urandom));
            if (k < 6) compareValue("rr_order", 0, 16'(gnt[0]), 16'(1 << (k % 3)));
            if (k >= 2) compareValue("rr_rsp", 0, 16'(rsp_valid[0]), 16'(1 << ((k - 2) % 3)));
        end

        // Locked 3x3 kernel burst from requester 0 while requester 1 waits.
        resetPulse();
        for (int k = 0; k < 9; k++) begin
            applyStimulus(3'b011, 3'b001, 6'h00, 9'(k / 3), 9'(k % 3));
            compareValue("burst_gnt", 0, 16'(gnt[0]), 16'h0001);
        end
        applyStimulus(3'b010, 3'b000, 6'h00, 9'h0, 9'h0);
        compareValue("lock_handoff", 0, 16'(gnt[0]), 16'h0002);

        // Lock ceiling on the LOCK_MAX=4 instance.
        resetPulse();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(3'b101, 3'b001, 6'($urandom), 9'($urandom), 9'($urandom));
            compareValue("lock_max_seq", 1, 16'(gnt[1]), 16'(exp32[k]));
        end

        // Reset right after a grant drops the pending response.
        resetPulse();
        applyStimulus(3'b001, 3'b000, 6'h3F, 9'h1FF, 9'h1FF);
        resetPulse();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(3'b000, 3'b000, '0, '0, '0);
            compareValue("rst_no_rsp", 0, 16'(rsp_valid[0]), 16'h0);
        end
        applyStimulus(3'b111, 3'b000, '0, '0, '0);
        compareValue("post_rst_gnt", 0, 16'(gnt[0]), 16'h0001);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(99) == 0) begin
                resetPulse();
            end else begin
                for (int b = 0; b < 3; b++) lr[b] = ($urandom_range(2) == 0);
                applyStimulus(3'($urandom), lr, 6'($urandom), 9'($urandom), 9'($urandom));
            end
        end

`ifdef MATARB_STATS_EN
        resetPulse();
        compareValue("stat_rst", 0, stat_cnt[0][31:16], 16'h0);
        for (int k = 0; k < 70000; k++)
            applyStimulus(3'b010, 3'b000, '0, '0, '0);
        applyStimulus(3'b010, 3'b000, '0, '0, '0);
        compareValue("stat_sat", 0, stat_cnt[0][31:16], 16'hFFFF);
        compareValue("stat_sat", 1, stat_cnt[1][31:16], 16'hFFFF);
        stat_clr = 1'b1;
        applyStimulus(3'b000, 3'b000, '0, '0, '0);
        stat_clr = 1'b0;
        compareValue("stat_clr", 0, stat_cnt[0][31:16], 16'h0);
        applyStimulus(3'b010, 3'b000, '0, '0, '0);
        applyStimulus(3'b000, 3'b000, '0, '0, '0);
        compareValue("stat_after_clr", 0, stat_cnt[0][31:16], 16'h0001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
